// File: rtl/taillight_request_scheduler.sv
// Taillight request scheduler: switch sync/debounce, request priority,
// and valid/ready command issue to the lamp pattern sequencer.
module taillight_request_scheduler #(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int GAP_TICKS      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       sw_haz,
    input  logic       cmd_ready,
    input  logic       seq_done,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [1:0] active,
    output logic       fault
);

    localparam int CW = (DEBOUNCE_TICKS < 1) ? 1
                      : $clog2(DEBOUNCE_TICKS + 1);
    localparam int GW = (GAP_TICKS < 1) ? 1
                      : $clog2(GAP_TICKS + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TICKS);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LEFT  = 2'b01;
    localparam logic [1:0] CMD_RIGHT = 2'b10;
    localparam logic [1:0] CMD_HAZ   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_GAP
    } state_t;

    // bit 0 left, bit 1 right, bit 2 hazard
    logic [2:0]    w_sw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_deb;
    logic [CW-1:0] r_db_cnt [3];

    logic          w_left;
    logic          w_right;
    logic          w_haz;
    logic [1:0]    w_req;

    state_t        r_state;
    logic          r_valid;
    logic [1:0]    r_cmd;
    logic [1:0]    r_active;
    logic          r_fault;
    logic [GW-1:0] r_gap_cnt;

    assign w_sw    = {sw_haz, sw_right, sw_left};
    assign w_left  = r_deb[0];
    assign w_right = r_deb[1];
    assign w_haz   = r_deb[2];

    // Two-flop synchronizer for the asynchronous switch levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_sw;
            r_sync2 <= r_sync1;
        end
    end

    // Per-switch debounce: flip only after DEBOUNCE_TICKS disagreeing ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_deb <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_deb[i]    <= ~r_deb[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Priority resolution: hazard (or both turns) beats left beats right
    always_comb begin
        w_req = CMD_NONE;
        if (w_haz | (w_left & w_right)) begin
            w_req = CMD_HAZ;
        end else if (w_left) begin
            w_req = CMD_LEFT;
        end else if (w_right) begin
            w_req = CMD_RIGHT;
        end
    end

    // Both turn switches on without hazard is flagged as a fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_left & w_right & ~w_haz;
        end
    end

    // Command FSM: issue, run, inter-pattern gap, hazard preemption
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_cmd     <= CMD_NONE;
            r_active  <= CMD_NONE;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req != CMD_NONE) begin
                        r_cmd   <= w_req;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        r_valid  <= 1'b0;
                        r_active <= r_cmd;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_req == CMD_HAZ && r_active != CMD_HAZ) begin
                        r_cmd   <= CMD_HAZ;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (seq_done) begin
                        r_active <= CMD_NONE;
                        if (GAP_TICKS > 0) begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= S_GAP;
                        end else if (w_req != CMD_NONE) begin
                            r_cmd   <= w_req;
                            r_valid <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (w_req == CMD_HAZ) begin
                        r_cmd   <= CMD_HAZ;
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (tick) begin
                        if (r_gap_cnt <= GAP_ONE) begin
                            r_gap_cnt <= '0;
                            if (w_req != CMD_NONE) begin
                                r_cmd   <= w_req;
                                r_valid <= 1'b1;
                                r_state <= S_ISSUE;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt - GW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid = r_valid;
    assign cmd       = r_cmd;
    assign active    = r_active;
    assign fault     = r_fault;

endmodule
